// File: rtl/density_scheduler.sv
// Walks every (i, j) particle pair through the pipelined density kernel and tags results with i.
// Optional DENSITY_SKIP_SELF_EN: the j == i self pair of each row is neither read nor issued.
module density_scheduler #(
  parameter int unsigned N         = 8,
  parameter int unsigned IDX_W     = $clog2(N),
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned TAG_DEPTH = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  output logic             pos_rd,
  output logic [IDX_W-1:0] pos_addr,
  input  logic [15:0]      pos_data,
  output logic [15:0]      k_r_i,
  output logic [15:0]      k_r_j,
  output logic             k_valid_in,
  input  logic [15:0]      k_result,
  input  logic             k_valid_out,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [15:0]      out_value,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAT_W = $clog2(READ_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  // Every pipe stage except the one returning this cycle.
  localparam logic [READ_LAT-1:0] NOT_TOP = ~(READ_LAT'(1) << (READ_LAT - 1));

  typedef enum logic [2:0] {StIdle, StLoadI, StStream, StFlush, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     i_q, i_d, j_q, j_d;
  logic [LAT_W-1:0]     ld_cnt_q, ld_cnt_d;
  logic [READ_LAT-1:0]  rd_pipe_q, ld_pipe_q;
  logic [LAT_W-1:0]     rd_cnt_q;
  logic [15:0]          r_i_q;
  logic [IDX_W-1:0]     tag_mem_q [TAG_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     tag_cnt_q;
  logic                 out_valid_q, err_q;
  logic [IDX_W-1:0]     out_idx_q;
  logic [15:0]          out_value_q;

  logic                 issue, ld_issue, ret, pop_ok, credit_ok, flush_clear;
  logic [IDX_W-1:0]     first_j, last_j, next_j;

`ifdef DENSITY_SKIP_SELF_EN
  assign first_j = (i_q == '0) ? IDX_W'(1) : '0;
  assign last_j  = (i_q == LAST_IDX) ? IDX_W'(N - 2) : LAST_IDX;
  assign next_j  = ((j_q + IDX_W'(1)) == i_q) ? j_q + IDX_W'(2) : j_q + IDX_W'(1);
`else
  assign first_j = '0;
  assign last_j  = LAST_IDX;
  assign next_j  = j_q + IDX_W'(1);
`endif

  assign ret         = rd_pipe_q[READ_LAT-1];
  assign pop_ok      = k_valid_out && (tag_cnt_q != '0);
  assign credit_ok   = (32'(tag_cnt_q) + 32'(rd_cnt_q)) < 32'(TAG_DEPTH);
  assign flush_clear = (rd_pipe_q & NOT_TOP) == '0;

  assign k_valid_in = ret;
  assign k_r_i      = ret ? r_i_q : '0;
  assign k_r_j      = ret ? pos_data : '0;
  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_value  = out_value_q;
  assign err        = err_q;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    ld_cnt_d = ld_cnt_q;
    pos_rd   = 1'b0;
    pos_addr = '0;
    issue    = 1'b0;
    ld_issue = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          state_d  = StLoadI;
          i_d      = '0;
          ld_cnt_d = '0;
        end
      end
      // The first STREAM read overlaps the cycle r_i arrives from the RAM.
      StLoadI: begin
        pos_addr = i_q;
        pos_rd   = (ld_cnt_q == '0);
        ld_issue = pos_rd;
        if (ld_cnt_q == LAT_W'(READ_LAT - 1)) begin
          state_d = StStream;
          j_d     = first_j;
        end else begin
          ld_cnt_d = ld_cnt_q + LAT_W'(1);
        end
      end
      StStream: begin
        pos_addr = j_q;
        if (credit_ok) begin
          pos_rd = 1'b1;
          issue  = 1'b1;
          if (j_q == last_j) state_d = StFlush;
          else               j_d     = next_j;
        end
      end
      StFlush: begin
        if (flush_clear) begin
          if (i_q == LAST_IDX) begin
            state_d = StDrain;
          end else begin
            state_d  = StLoadI;
            i_d      = i_q + IDX_W'(1);
            ld_cnt_d = '0;
          end
        end
      end
      StDrain: begin
        if (tag_cnt_q == '0) state_d = StDone;
      end
      StDone: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= StIdle;
      i_q         <= '0;
      j_q         <= '0;
      ld_cnt_q    <= '0;
      rd_pipe_q   <= '0;
      ld_pipe_q   <= '0;
      rd_cnt_q    <= '0;
      r_i_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tag_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_value_q <= '0;
      err_q       <= 1'b0;
      for (int k = 0; k < TAG_DEPTH; k++) tag_mem_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      ld_cnt_q  <= ld_cnt_d;
      rd_pipe_q <= (rd_pipe_q << 1) | READ_LAT'(issue);
      ld_pipe_q <= (ld_pipe_q << 1) | READ_LAT'(ld_issue);
      rd_cnt_q  <= rd_cnt_q + LAT_W'(issue) - LAT_W'(ret);
      if (ld_pipe_q[READ_LAT-1]) r_i_q <= pos_data;

      // Returning reads always belong to the current row, so i_q is the right tag.
      if (ret) begin
        tag_mem_q[wr_ptr_q] <= i_q;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        out_idx_q   <= tag_mem_q[rd_ptr_q];
        out_value_q <= k_result;
      end
      out_valid_q <= pop_ok;
      case ({ret, pop_ok})
        2'b10:   tag_cnt_q <= tag_cnt_q + CNT_W'(1);
        2'b01:   tag_cnt_q <= tag_cnt_q - CNT_W'(1);
        default: tag_cnt_q <= tag_cnt_q;
      endcase
      if (k_valid_out && (tag_cnt_q == '0)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_density_scheduler.sv
// Directed bench for density_scheduler: RAM and H=1.0 kernel models, result log, immediate asserts.
`timescale 1ns/1ps
module tb_density_scheduler;
  localparam int unsigned N         = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned READ_LAT  = 2;
  localparam int unsigned TAG_DEPTH = 8;
`ifdef DENSITY_SKIP_SELF_EN
  localparam int PAIRS   = N * (N - 1);
  localparam int FIRST_J = 1;
`else
  localparam int PAIRS   = N * N;
  localparam int FIRST_J = 0;
`endif

  logic             clk_in = 1'b0;
  logic             rst, start, inj;
  logic             pos_rd, k_valid_in, k_valid_out, out_valid, busy, done, err;
  logic [IDX_W-1:0] pos_addr, out_idx;
  logic [15:0]      pos_data, k_r_i, k_r_j, k_result, out_value;

  density_scheduler #(
    .N(N), .IDX_W(IDX_W), .READ_LAT(READ_LAT), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .pos_rd(pos_rd), .pos_addr(pos_addr),
    .pos_data(pos_data), .k_r_i(k_r_i), .k_r_j(k_r_j), .k_valid_in(k_valid_in),
    .k_result(k_result), .k_valid_out(k_valid_out), .out_valid(out_valid), .out_idx(out_idx),
    .out_value(out_value), .busy(busy), .done(done), .err(err)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Position RAM: data appears READ_LAT cycles after a strobed read, 0xDEAD otherwise.
  logic [15:0]      pos_mem [N];
  logic [IDX_W-1:0] ra_q [READ_LAT];
  logic             rv_q [READ_LAT];
  always @(posedge clk_in) begin
    ra_q[0] <= pos_addr;
    rv_q[0] <= pos_rd;
    for (int k = 1; k < READ_LAT; k++) begin
      ra_q[k] <= ra_q[k-1];
      rv_q[k] <= rv_q[k-1];
    end
  end
  assign pos_data = rv_q[READ_LAT-1] ? pos_mem[ra_q[READ_LAT-1]] : 16'hDEAD;

  function automatic int halves(input logic [15:0] v);
    case (v)
      16'h0000: return 0;
      16'h3800: return 1;
      16'h3C00: return 2;
      16'h4000: return 4;
      default:  return -100;
    endcase
  endfunction

  // Triangle kernel with H=1.0 over the four test positions.
  function automatic logic [15:0] kern_w(input logic [15:0] a, input logic [15:0] b);
    int d;
    if (halves(a) < 0 || halves(b) < 0) return 16'hBAD0;
    d = halves(a) - halves(b);
    if (d < 0) d = -d;
    if (d == 0) return 16'h3C00;
    if (d == 1) return 16'h3800;
    return 16'h0000;
  endfunction

  logic [5:0]  cyc = '0;
  logic [5:0]  kern_lat;
  logic        kv_slot [64];
  logic [15:0] kr_slot [64];
  always @(posedge clk_in) begin
    cyc <= cyc + 6'd1;
    if (rst) begin
      for (int k = 0; k < 64; k++) kv_slot[k] <= 1'b0;
    end else begin
      kv_slot[cyc] <= 1'b0;
      if (k_valid_in) begin
        kv_slot[cyc + kern_lat] <= 1'b1;
        kr_slot[cyc + kern_lat] <= kern_w(k_r_i, k_r_j);
      end
    end
  end
  assign k_valid_out = kv_slot[cyc] | inj;
  assign k_result    = kr_slot[cyc];

  int               res_cnt = 0, done_cnt = 0, kin_cnt = 0, kout_cnt = 0, max_infl = 0;
  int               ncyc = 0, last_out_cyc = 0, done_cyc = 0;
  logic             busy_at_done;
  logic [IDX_W-1:0] idx_log [64];
  logic [15:0]      val_log [64];
  always @(negedge clk_in) begin
    ncyc++;
    if (out_valid) begin
      if (res_cnt < 64) begin
        idx_log[res_cnt] = out_idx;
        val_log[res_cnt] = out_value;
      end
      res_cnt++;
      last_out_cyc = ncyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc     = ncyc;
      busy_at_done = busy;
    end
    if (k_valid_in)  kin_cnt++;
    if (k_valid_out) kout_cnt++;
    if (kin_cnt - kout_cnt > max_infl) max_infl = kin_cnt - kout_cnt;
  end

  task automatic clear_log();
    res_cnt  = 0;
    done_cnt = 0;
    kin_cnt  = 0;
    kout_cnt = 0;
    max_infl = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk_in); #1 start = 1'b1;
    @(posedge clk_in); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk_in);
      k++;
    end
    chk("done_seen", 32'(done_cnt != 0), 32'd1);
    repeat (3) @(negedge clk_in);
  endtask

  logic [IDX_W-1:0] exp_idx [PAIRS];
  logic [15:0]      exp_val [PAIRS];

  task automatic check_results(input string tag);
    chk({tag, "_count"}, 32'(res_cnt), 32'(PAIRS));
    for (int k = 0; k < PAIRS && k < res_cnt; k++) begin
      chk({tag, "_idx"}, 32'(idx_log[k]), 32'(exp_idx[k]));
      chk({tag, "_val"}, 32'(val_log[k]), 32'(exp_val[k]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pos_rd"}, 32'(pos_rd), 32'd0);
    chk({tag, "_pos_addr"}, 32'(pos_addr), 32'd0);
    chk({tag, "_k_valid_in"}, 32'(k_valid_in), 32'd0);
    chk({tag, "_k_r_i"}, 32'(k_r_i), 32'd0);
    chk({tag, "_k_r_j"}, 32'(k_r_j), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    chk({tag, "_out_value"}, 32'(out_value), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [15:0] row0 [N];
    int          e;
    int          k;
    rst      = 1'b1;
    start    = 1'b0;
    inj      = 1'b0;
    kern_lat = 6'd4;
    pos_mem[0] = 16'h0000;
    pos_mem[1] = 16'h3800;
    pos_mem[2] = 16'h3C00;
    pos_mem[3] = 16'h4000;
`ifdef DENSITY_SKIP_SELF_EN
    row0[0] = 16'h3800; row0[1] = 16'h0000; row0[2] = 16'h0000; row0[3] = 16'h0000;
`else
    row0[0] = 16'h3C00; row0[1] = 16'h3800; row0[2] = 16'h0000; row0[3] = 16'h0000;
`endif
    e = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
`ifdef DENSITY_SKIP_SELF_EN
        if (i == j) continue;
`endif
        exp_idx[e] = IDX_W'(i);
        exp_val[e] = kern_w(pos_mem[i], pos_mem[j]);
        e++;
      end
    end

    // Reset state
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_all_zero("reset");
    @(posedge clk_in); #1 rst = 1'b0;

    // Full step, 4-cycle kernel: latency, results, done timing
    clear_log();
    pulse_start();
    @(negedge clk_in);
    chk("first_pos_rd", 32'(pos_rd), 32'd1);
    chk("busy_after_start", 32'(busy), 32'd1);
    repeat (3) @(negedge clk_in);
    chk("kvin_not_early", 32'(k_valid_in), 32'd0);
    @(negedge clk_in);
    chk("first_kvin", 32'(k_valid_in), 32'd1);
    chk("first_k_r_i", 32'(k_r_i), 32'(pos_mem[0]));
    chk("first_k_r_j", 32'(k_r_j), 32'(pos_mem[FIRST_J]));
    wait_done(400);
    check_results("step");
    for (int j = 0; j < N - FIRST_J; j++) begin
      chk("row0_idx", 32'(idx_log[j]), 32'd0);
      chk("row0_val", 32'(val_log[j]), 32'(row0[j]));
    end
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("busy_at_done", 32'(busy_at_done), 32'd0);
    chk("done_after_last_out", 32'(done_cyc - last_out_cyc), 32'd1);
    chk("step_err", 32'(err), 32'd0);

    // 20-cycle kernel forces credit stalls
    kern_lat = 6'd20;
    clear_log();
    pulse_start();
    wait_done(1500);
    check_results("stall");
    chk("stall_infl_bound", 32'(max_infl <= TAG_DEPTH), 32'd1);
    chk("stall_infl_reached", 32'(max_infl), 32'(TAG_DEPTH));
    chk("stall_done_once", 32'(done_cnt), 32'd1);
    chk("stall_err", 32'(err), 32'd0);

    // Second start during STREAM is ignored
    kern_lat = 6'd4;
    clear_log();
    pulse_start();
    repeat (4) @(posedge clk_in);
    #1 start = 1'b1;
    @(posedge clk_in); #1 start = 1'b0;
    wait_done(400);
    repeat (30) @(negedge clk_in);
    chk("restart_count", 32'(res_cnt), 32'(PAIRS));
    chk("restart_done_once", 32'(done_cnt), 32'd1);
    chk("restart_busy", 32'(busy), 32'd0);

    // Reset in the middle of row 2, then a clean step
    clear_log();
    pulse_start();
    k = 0;
    while (!(k_valid_in && k_r_i == pos_mem[2]) && k < 400) begin
      @(negedge clk_in);
      k++;
    end
    chk("row2_reached", 32'(k_valid_in && k_r_i == pos_mem[2]), 32'd1);
    @(posedge clk_in); #1 rst = 1'b1;
    @(posedge clk_in); #1 rst = 1'b0;
    clear_log();
    @(negedge clk_in);
    check_all_zero("midrst");
    repeat (40) @(negedge clk_in);
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    chk("midrst_no_out", 32'(res_cnt), 32'd0);
    pulse_start();
    wait_done(400);
    check_results("after_rst");
    chk("after_rst_done", 32'(done_cnt), 32'd1);

    // Stray kernel result while idle
    clear_log();
    @(posedge clk_in); #1 inj = 1'b1;
    @(posedge clk_in); #1 inj = 1'b0;
    @(negedge clk_in);
    chk("inj_err_set", 32'(err), 32'd1);
    chk("inj_no_out", 32'(out_valid), 32'd0);
    repeat (5) @(negedge clk_in);
    chk("inj_err_sticky", 32'(err), 32'd1);
    chk("inj_no_results", 32'(res_cnt), 32'd0);
    @(posedge clk_in); #1 rst = 1'b1;
    @(posedge clk_in); #1 rst = 1'b0;
    @(negedge clk_in);
    chk("err_cleared", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
